// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: issue-stage hazard query, ALU/LSU writeback
// handshakes, register file write port and scoreboard status.
// master: the surrounding pipeline (drives requests, sees stall/ready/write port)
// slave : regfile_wb_scheduler itself
interface regfile_wb_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  // issue stage
  logic             issue_valid;
  logic [4:0]       issue_rs1;
  logic [4:0]       issue_rs2;
  logic             issue_rs1_used;
  logic             issue_rs2_used;
  logic [4:0]       issue_rd;
  logic             issue_rd_we;
  logic             issue_stall;

  // ALU writeback
  logic             alu_wb_valid;
  logic [4:0]       alu_wb_rd;
  logic [WIDTH-1:0] alu_wb_data;
  logic             alu_wb_ready;

  // LSU writeback
  logic             lsu_wb_valid;
  logic [4:0]       lsu_wb_rd;
  logic [WIDTH-1:0] lsu_wb_data;
  logic             lsu_wb_ready;

  // register file write port and status
  logic             rf_write_en;
  logic [4:0]       rf_rd_addr;
  logic [WIDTH-1:0] rf_write_data;
  logic [DEPTH-1:0] busy_vec;
  logic             wb_error;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_we,
    input  issue_stall,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  alu_wb_ready,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  lsu_wb_ready,
    input  rf_write_en, rf_rd_addr, rf_write_data, busy_vec, wb_error
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_rd_we,
    output issue_stall,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    output alu_wb_ready,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output lsu_wb_ready,
    output rf_write_en, rf_rd_addr, rf_write_data, busy_vec, wb_error
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the single register file write port between
// the ALU and LSU writeback paths and keeps a per-register pending-write
// scoreboard that stalls issue on RAW/WAW hazards.
// Build option: WB_ARB_ROUND_ROBIN_EN selects two-way round-robin
// arbitration; when undefined the LSU has fixed priority over the ALU.
// Reset is synchronous and active-low.
module regfile_wb_scheduler #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_wb_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LSU  = 2'd2
  } grant_t;

  // scoreboard and write-port registers
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic             rf_write_en_reg;
  logic [4:0]       rf_rd_addr_reg;
  logic [WIDTH-1:0] rf_write_data_reg;
  logic             wb_error_reg;

  // arbitration results
  grant_t           grant_sel;
  logic             grant_valid;
  logic [4:0]       grant_rd;
  logic [WIDTH-1:0] grant_data;
  logic             grant_writes;
  logic             grant_err;

  // issue side
  logic             hazard;
  logic             issue_stall_int;
  logic             issue_accept;
  logic             set_en;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clear_mask;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // 1 = the ALU won the most recent grant, so the LSU is preferred next
  logic             last_alu_reg;
`endif

  // Pick at most one writeback source per cycle; nothing is granted in reset.
  always_comb begin
    grant_sel = GRANT_NONE;
    if (reset) begin
      if (bus.lsu_wb_valid && bus.alu_wb_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        grant_sel = last_alu_reg ? GRANT_LSU : GRANT_ALU;
`else
        grant_sel = GRANT_LSU;
`endif
      end else if (bus.lsu_wb_valid) begin
        grant_sel = GRANT_LSU;
      end else if (bus.alu_wb_valid) begin
        grant_sel = GRANT_ALU;
      end
    end
  end

  // Steer the winner's payload and flag writebacks to registers not pending.
  always_comb begin
    grant_valid  = 1'b0;
    grant_rd     = '0;
    grant_data   = '0;
    case (grant_sel)
      GRANT_LSU: begin
        grant_valid = 1'b1;
        grant_rd    = bus.lsu_wb_rd;
        grant_data  = bus.lsu_wb_data;
      end
      GRANT_ALU: begin
        grant_valid = 1'b1;
        grant_rd    = bus.alu_wb_rd;
        grant_data  = bus.alu_wb_data;
      end
      default: begin
        grant_valid = 1'b0;
      end
    endcase
    // x0 writebacks are consumed silently: no write, no error
    grant_writes = grant_valid && (grant_rd != 5'd0);
    grant_err    = grant_writes && !busy_reg[grant_rd];
  end

  // Hazard check uses only the registered busy bits, so a clear landing on
  // this edge does not release the stall until the next cycle.
  always_comb begin
    hazard = (bus.issue_rs1_used && busy_reg[bus.issue_rs1]) ||
             (bus.issue_rs2_used && busy_reg[bus.issue_rs2]) ||
             (bus.issue_rd_we    && busy_reg[bus.issue_rd]);
    issue_stall_int = reset && bus.issue_valid && hazard;
    issue_accept    = reset && bus.issue_valid && !hazard;
    set_en          = issue_accept && bus.issue_rd_we && (bus.issue_rd != 5'd0);
  end

  // Per-register set/clear decode; set takes precedence, x0 is never busy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      assign set_mask[gi]   = set_en && (bus.issue_rd == gi[4:0]);
      assign clear_mask[gi] = rf_write_en_reg && (rf_rd_addr_reg == gi[4:0]);
      if (gi == 0) begin : g_x0
        assign busy_next[gi] = 1'b0;
      end else begin : g_xn
        assign busy_next[gi] = set_mask[gi] | (busy_reg[gi] & ~clear_mask[gi]);
      end
    end
  endgenerate

  // Scoreboard, registered write port and sticky error flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_reg          <= '0;
      rf_write_en_reg   <= 1'b0;
      rf_rd_addr_reg    <= '0;
      rf_write_data_reg <= '0;
      wb_error_reg      <= 1'b0;
    end else begin
      busy_reg        <= busy_next;
      rf_write_en_reg <= grant_writes;
      // address/data hold their last value when nothing is granted
      if (grant_valid) begin
        rf_rd_addr_reg    <= grant_rd;
        rf_write_data_reg <= grant_data;
      end
      if (grant_err) begin
        wb_error_reg <= 1'b1;
      end
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Remember which source won last; only moves when something is granted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_alu_reg <= 1'b1;
    end else if (grant_valid) begin
      last_alu_reg <= (grant_sel == GRANT_ALU);
    end
  end
`endif

  assign bus.issue_stall   = issue_stall_int;
  assign bus.alu_wb_ready  = (grant_sel == GRANT_ALU);
  assign bus.lsu_wb_ready  = (grant_sel == GRANT_LSU);
  assign bus.rf_write_en   = rf_write_en_reg;
  assign bus.rf_rd_addr    = rf_rd_addr_reg;
  assign bus.rf_write_data = rf_write_data_reg;
  assign bus.busy_vec      = busy_reg;
  assign bus.wb_error      = wb_error_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Testbench for regfile_wb_scheduler: directed scenarios followed by random
// traffic, every cycle compared against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  regfile_wb_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_wb_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          m_busy [32];
  bit          m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_last_alu;
  // expected combinational responses for the current cycle
  bit          e_stall, e_alu, e_lsu;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_en = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0; m_last_alu = 1'b1;
  endtask

  // What the block must answer this cycle, from the model's registered state.
  task automatic model_comb();
    bit hz;
    hz = (bus.issue_rs1_used && m_busy[bus.issue_rs1]) ||
         (bus.issue_rs2_used && m_busy[bus.issue_rs2]) ||
         (bus.issue_rd_we && m_busy[bus.issue_rd]);
    e_stall = reset && bus.issue_valid && hz;
    e_alu = 1'b0;
    e_lsu = 1'b0;
    if (reset) begin
      if (bus.lsu_wb_valid && bus.alu_wb_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (m_last_alu) e_lsu = 1'b1; else e_alu = 1'b1;
`else
        e_lsu = 1'b1;
`endif
      end else begin
        e_lsu = bus.lsu_wb_valid;
        e_alu = bus.alu_wb_valid;
      end
    end
  endtask

  // Apply the clock edge to the model.
  task automatic model_edge();
    bit          old_busy [32];
    bit          g;
    logic [4:0]  wrd;
    logic [31:0] wd;
    if (!reset) begin
      model_reset();
      return;
    end
    old_busy = m_busy;
    g   = e_lsu || e_alu;
    wrd = e_lsu ? bus.lsu_wb_rd : bus.alu_wb_rd;
    wd  = e_lsu ? bus.lsu_wb_data : bus.alu_wb_data;
    if (m_en) m_busy[m_addr] = 1'b0;
    if (bus.issue_valid && !e_stall && bus.issue_rd_we && bus.issue_rd != 5'd0)
      m_busy[bus.issue_rd] = 1'b1;
    if (g && wrd != 5'd0 && !old_busy[wrd]) m_err = 1'b1;
    m_en = g && (wrd != 5'd0);
    if (g) begin
      m_addr     = wrd;
      m_data     = wd;
      m_last_alu = e_alu;
    end
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then registers.
  task automatic step();
    logic [31:0] bv;
    model_comb();
    @(negedge clock);
    check_value("issue_stall", bus.issue_stall, e_stall);
    check_value("lsu_wb_ready", bus.lsu_wb_ready, e_lsu);
    check_value("alu_wb_ready", bus.alu_wb_ready, e_alu);
    if (e_lsu) $display("t=%0t wb LSU rd=%0d data=%h", $time, bus.lsu_wb_rd, bus.lsu_wb_data);
    if (e_alu) $display("t=%0t wb ALU rd=%0d data=%h", $time, bus.alu_wb_rd, bus.alu_wb_data);
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
    check_value("busy_vec", bus.busy_vec, bv);
    check_value("rf_write_en", bus.rf_write_en, m_en);
    check_value("wb_error", bus.wb_error, m_err);
    if (m_en) begin
      check_value("rf_rd_addr", bus.rf_rd_addr, m_addr);
      check_value("rf_write_data", bus.rf_write_data, m_data);
    end
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
    bus.issue_rs1_used = 0; bus.issue_rs2_used = 0; bus.issue_rd = 0; bus.issue_rd_we = 0;
    bus.alu_wb_valid = 0; bus.alu_wb_rd = 0; bus.alu_wb_data = 0;
    bus.lsu_wb_valid = 0; bus.lsu_wb_rd = 0; bus.lsu_wb_data = 0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    bus.issue_valid = 1; bus.issue_rd = rd; bus.issue_rd_we = 1;
    bus.issue_rs1_used = 0; bus.issue_rs2_used = 0;
    step();
    bus.issue_valid = 0; bus.issue_rd_we = 0;
  endtask

  // Writeback targets are mostly registers the model says are pending.
  function automatic logic [4:0] pick_rd();
    int cand [$];
    for (int i = 1; i < 32; i++) if (m_busy[i]) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(0, 9) < 8)
      return 5'(cand[$urandom_range(0, cand.size() - 1)]);
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    model_reset();
    reset = 0;
    #1;

    // reset then idle
    step(); step();
    reset = 1;
    step();
    check_value("reset_busy_vec", bus.busy_vec, 0);
    check_value("reset_rf_write_en", bus.rf_write_en, 0);
    check_value("reset_wb_error", bus.wb_error, 0);
    check_value("reset_issue_stall", bus.issue_stall, 0);

    // RAW stall and write latency
    issue_write(5'd5);
    check_value("raw_busy5_set", bus.busy_vec[5], 1);
    bus.issue_valid = 1; bus.issue_rs1 = 5; bus.issue_rs1_used = 1;
    #1 check_value("raw_stall", bus.issue_stall, 1);
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 5; bus.alu_wb_data = 32'hDEADBEEF;
    step();                                   // cycle N: grant
    bus.alu_wb_valid = 0;
    check_value("raw_wr_en", bus.rf_write_en, 1);
    check_value("raw_wr_addr", bus.rf_rd_addr, 5);
    check_value("raw_wr_data", bus.rf_write_data, 32'hDEADBEEF);
    #1 check_value("raw_stall_n1", bus.issue_stall, 1);
    step();                                   // cycle N+1: commit
    #1 check_value("raw_stall_n2", bus.issue_stall, 0);
    step();
    clear_inputs();

    // contention between ALU and LSU
    issue_write(5'd3);
    issue_write(5'd4);
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 3; bus.alu_wb_data = 32'h3333_0003;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 4; bus.lsu_wb_data = 32'h4444_0004;
    #1 check_value("cont_lsu_first", bus.lsu_wb_ready, 1);
    step();
    bus.lsu_wb_valid = 0;
    check_value("cont_addr_lsu", bus.rf_rd_addr, 4);
    step();
    bus.alu_wb_valid = 0;
    check_value("cont_addr_alu", bus.rf_rd_addr, 3);
    step();

    // WAW stall and set-wins on a same-edge clear
    issue_write(5'd9);
    bus.issue_valid = 1; bus.issue_rd = 9; bus.issue_rd_we = 1;
    #1 check_value("waw_stall", bus.issue_stall, 1);
    step();
    bus.issue_valid = 0; bus.issue_rd_we = 0;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 9; bus.lsu_wb_data = 32'h9;
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 9; bus.alu_wb_data = 32'h99;
    step();
    bus.lsu_wb_valid = 0;
    step();
    bus.alu_wb_valid = 0;
    check_value("sw_busy9_clear", bus.busy_vec[9], 0);
    check_value("sw_wr_addr9", bus.rf_rd_addr, 9);
    bus.issue_valid = 1; bus.issue_rd = 9; bus.issue_rd_we = 1;
    #1 check_value("sw_issue_ok", bus.issue_stall, 0);
    step();
    clear_inputs();
    check_value("sw_busy9_set", bus.busy_vec[9], 1);
    check_value("sw_no_error", bus.wb_error, 0);
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 9; bus.alu_wb_data = 32'h999;
    step();
    bus.alu_wb_valid = 0;
    step(); step();

    // writeback to x0
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 0; bus.lsu_wb_data = 32'h1234;
    #1 check_value("x0_ready", bus.lsu_wb_ready, 1);
    step();
    bus.lsu_wb_valid = 0;
    check_value("x0_no_write", bus.rf_write_en, 0);
    check_value("x0_no_error", bus.wb_error, 0);
    step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if (!bus.alu_wb_valid || e_alu) begin
        bus.alu_wb_valid = ($urandom_range(0, 2) == 0);
        bus.alu_wb_rd    = pick_rd();
        bus.alu_wb_data  = $urandom;
      end
      if (!bus.lsu_wb_valid || e_lsu) begin
        bus.lsu_wb_valid = ($urandom_range(0, 2) == 0);
        bus.lsu_wb_rd    = pick_rd();
        bus.lsu_wb_data  = $urandom;
      end
      bus.issue_valid    = ($urandom_range(0, 9) < 7);
      bus.issue_rs1      = 5'($urandom_range(0, 15));
      bus.issue_rs2      = 5'($urandom_range(0, 15));
      bus.issue_rd       = 5'($urandom_range(0, 15));
      bus.issue_rs1_used = 1'($urandom_range(0, 1));
      bus.issue_rs2_used = 1'($urandom_range(0, 1));
      bus.issue_rd_we    = 1'($urandom_range(0, 1));
      step();
    end
    clear_inputs();

    // sticky error on a writeback to a non-busy register
    reset = 0;
    step(); step();
    reset = 1;
    step();
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 7; bus.alu_wb_data = 32'h7777_7777;
    step();
    bus.alu_wb_valid = 0;
    check_value("err_write_en", bus.rf_write_en, 1);
    check_value("err_write_addr", bus.rf_rd_addr, 7);
    check_value("err_flag_set", bus.wb_error, 1);
    step(); step();
    check_value("err_flag_sticky", bus.wb_error, 1);

    // reset in the middle of operation
    issue_write(5'd1);
    issue_write(5'd2);
    issue_write(5'd3);
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 1; bus.lsu_wb_data = 32'hA1;
    step();
    bus.lsu_wb_rd = 2; bus.lsu_wb_data = 32'hA2;
    reset = 0;
    #1 check_value("rst_no_ready", bus.lsu_wb_ready, 0);
    step();
    check_value("rst_write_en", bus.rf_write_en, 0);
    check_value("rst_busy_vec", bus.busy_vec, 0);
    check_value("rst_wb_error", bus.wb_error, 0);
    reset = 1;
    bus.lsu_wb_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
